// File: rtl/register_file_write_arbiter.sv
// Two-requester write arbiter in front of a register file, with a clear
// sweep that zeroes registers 1..2^ADDR_W-1. Register 0 is never written.
// All outputs except the ready signals are registered.
module register_file_write_arbiter #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [N-1:0]             req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [N-1:0]             req1_data,
  output logic                     req1_ready,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic [(1<<ADDR_W)-1:0]   reg_enable,
  output logic [N-1:0]             reg_data,
  output logic [7:0]               conflict_count
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;         // sweep index, register being zeroed
  logic              last_grant;  // 1: requester 1 was granted most recently
  logic              both;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [N-1:0]      xfer_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a clear request wins in IDLE; the sweep ends after the last register
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (&idx)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant logic: only in IDLE without a pending clear, round-robin on contention
  always_comb begin
    logic allow;
    allow      = (state == IDLE) && !clear_start && !reset;
    both       = req0_valid && req1_valid;
    req0_ready = allow && req0_valid && (!req1_valid ||  last_grant);
    req1_ready = allow && req1_valid && (!req0_valid || !last_grant);
    xfer       = req0_ready || req1_ready;
    xfer_addr  = req1_ready ? req1_addr : req0_addr;
    xfer_data  = req1_ready ? req1_data : req0_data;
  end

  assign clear_busy = (state == CLEAR);

  // Datapath: one-cycle write strobe from a transfer or a sweep step, plus
  // round-robin history and the saturating contention counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx            <= ADDR_W'(1);
      last_grant     <= 1'b1;
      reg_enable     <= '0;
      reg_data       <= '0;
      conflict_count <= '0;
    end else begin
      reg_enable <= '0;
      if (state == CLEAR) begin
        reg_enable <= NREG'(1) << idx;
        reg_data   <= '0;
        idx        <= idx + ADDR_W'(1);
      end else if (clear_start) begin
        idx <= ADDR_W'(1);
      end else if (xfer) begin
        // bit 0 masked: register 0 is hardwired and accepts no writes
        reg_enable <= (NREG'(1) << xfer_addr) & ~NREG'(1);
        reg_data   <= xfer_data;
        last_grant <= req1_ready;
        if (both && conflict_count != 8'hFF)
          conflict_count <= conflict_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Directed bench for register_file_write_arbiter: reset, single write,
// contention, address 0, clear sweep vs. pending request, reset mid-sweep,
// counter saturation.
module tb_register_file_write_arbiter;

  localparam int N      = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [N-1:0]      req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              clear_start, clear_busy;
  logic [31:0]       reg_enable;
  logic [N-1:0]      reg_data;
  logic [7:0]        conflict_count;

  int n_vec = 0;
  int n_err = 0;

  register_file_write_arbiter #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .reg_enable(reg_enable), .reg_data(reg_data), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one cycle; leaves time at posedge+1
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    req0_valid = 1;
    tick(); tick();
    // reset state; ready blocked while reset is high
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_en", reg_enable, 0);
    chk("rst_data", reg_data, 0);
    chk("rst_cnt", conflict_count, 0);
    reset = 0;
    idle_inputs();
    tick();

    // single write
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    #1;
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("wr_en", reg_enable, 64'h20);
    chk("wr_data", reg_data, 64'hDEADBEEF);
    tick();
    chk("wr_en_1cyc", reg_enable, 0);
    chk("wr_data_hold", reg_data, 64'hDEADBEEF);

    // contention after reset: 0,1,0,1
    do_reset();
    req0_valid = 1; req0_addr = 3; req0_data = 32'hA0;
    req1_valid = 1; req1_addr = 7; req1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ct_ready0_%0d", i), req0_ready, (i % 2 == 0));
      chk($sformatf("ct_ready1_%0d", i), req1_ready, (i % 2 == 1));
      tick();
      chk($sformatf("ct_en_%0d", i), reg_enable, (i % 2 == 0) ? 64'h8 : 64'h80);
      chk($sformatf("ct_data_%0d", i), reg_data, (i % 2 == 0) ? 64'hA0 : 64'hB1);
    end
    idle_inputs();
    chk("ct_cnt", conflict_count, 4);

    // address 0 is accepted but never written
    req1_valid = 1; req1_addr = 0; req1_data = 32'h1234;
    #1;
    chk("a0_ready1", req1_ready, 1);
    tick();
    idle_inputs();
    chk("a0_en", reg_enable, 0);
    chk("a0_cnt", conflict_count, 4);

    // clear sweep coinciding with req1; stray clear_start mid-sweep ignored
    clear_start = 1;
    req1_valid = 1; req1_addr = 9; req1_data = 32'h55;
    #1;
    chk("cl_ready1_c0", req1_ready, 0);
    tick();
    clear_start = 0;
    for (int k = 1; k < 32; k++) begin
      clear_start = (k == 15);
      #1;
      chk($sformatf("cl_busy_%0d", k), clear_busy, 1);
      chk($sformatf("cl_ready1_%0d", k), req1_ready, 0);
      tick();
      chk($sformatf("cl_en_%0d", k), reg_enable, 64'(1) << k);
      chk($sformatf("cl_data_%0d", k), reg_data, 0);
    end
    clear_start = 0;
    #1;
    chk("cl_busy_end", clear_busy, 0);
    chk("cl_ready1_end", req1_ready, 1);
    tick();
    idle_inputs();
    chk("cl_req1_en", reg_enable, 64'h200);
    chk("cl_req1_data", reg_data, 64'h55);
    tick();
    chk("cl_no_restart", clear_busy, 0);

    // reset during a sweep abandons it
    clear_start = 1;
    tick();
    clear_start = 0;
    for (int c = 1; c < 10; c++) tick();
    chk("rm_busy_before", clear_busy, 1);
    reset = 1;
    req0_valid = 1; req0_addr = 2; req0_data = 32'h77;
    #1;
    chk("rm_ready_in_rst", req0_ready, 0);
    tick();
    reset = 0;
    chk("rm_busy", clear_busy, 0);
    chk("rm_en", reg_enable, 0);
    #1;
    chk("rm_ready0", req0_ready, 1);
    tick();
    idle_inputs();
    chk("rm_en_wr", reg_enable, 64'h4);
    tick(); tick();
    chk("rm_no_resume", clear_busy, 0);
    chk("rm_en_idle", reg_enable, 0);

    // saturation
    do_reset();
    req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
    for (int i = 0; i < 300; i++) tick();
    idle_inputs();
    chk("sat_cnt", conflict_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
